// File: rtl/nanorv32_ahb_master_bridge_pkg.sv
// Shared AHB-Lite encodings and bridge FSM states for nanorv32 AHB initiators.
package nanorv32_ahb_master_bridge_pkg;

    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;

    localparam logic [2:0] HSIZE_BYTE = 3'b000;
    localparam logic [2:0] HSIZE_HALF = 3'b001;
    localparam logic [2:0] HSIZE_WORD = 3'b010;

    localparam logic [2:0] HBURST_SINGLE = 3'b000;

    typedef enum logic [2:0] {
        StIdle,
        StAddr,
        StData,
        StErr2,
        StDone
    } bridge_state_e;

endpackage

// File: rtl/nanorv32_ahb_bytesel_decode.sv
// Maps a native byte-select mask to AHB transfer size and low address bits.
module nanorv32_ahb_bytesel_decode
    import nanorv32_ahb_master_bridge_pkg::*;
(
    input  logic [3:0] bytesel_i,
    output logic [2:0] hsize_o,
    output logic [1:0] addr_lo_o,
    output logic       legal_o
);

    always_comb begin
        hsize_o   = HSIZE_BYTE;
        addr_lo_o = 2'b00;
        legal_o   = 1'b1;
        case (bytesel_i)
            4'b1111: hsize_o = HSIZE_WORD;
            4'b0011: hsize_o = HSIZE_HALF;
            4'b1100: begin
                hsize_o   = HSIZE_HALF;
                addr_lo_o = 2'b10;
            end
            4'b0001: addr_lo_o = 2'b00;
            4'b0010: addr_lo_o = 2'b01;
            4'b0100: addr_lo_o = 2'b10;
            4'b1000: addr_lo_o = 2'b11;
            default: legal_o = 1'b0;
        endcase
    end

endmodule

// File: rtl/nanorv32_ahb_master_bridge.sv
// Native single-transfer request bus to AHB-Lite master: one non-pipelined
// SINGLE transfer per request, registered outputs on both sides.
module nanorv32_ahb_master_bridge
    import nanorv32_ahb_master_bridge_pkg::*;
#(
    parameter int unsigned AW        = 32,
    parameter logic [3:0]  HPROT_VAL = 4'b0011
) (
    input  logic          clk,
    input  logic          rst_n,

    input  logic          req_en,
    input  logic [AW-1:0] req_addr,
    input  logic          req_we,
    input  logic [3:0]    req_bytesel,
    input  logic [31:0]   req_wdata,
    output logic          req_ready,
    output logic [31:0]   req_rdata,
    output logic          req_err,

    output logic [AW-1:0] haddr,
    output logic [1:0]    htrans,
    output logic          hwrite,
    output logic [2:0]    hsize,
    output logic [2:0]    hburst,
    output logic [3:0]    hprot,
    output logic          hmastlock,
    output logic [31:0]   hwdata,
    input  logic [31:0]   hrdata,
    input  logic          hready,
    input  logic          hresp
);

    bridge_state_e state_q, state_d;

    logic [AW-1:0] haddr_q, haddr_d;
    logic [1:0]    htrans_q, htrans_d;
    logic          hwrite_q, hwrite_d;
    logic [2:0]    hsize_q, hsize_d;
    logic [31:0]   hwdata_q, hwdata_d;
    logic [31:0]   wdata_q, wdata_d;
    logic          ready_q, ready_d;
    logic [31:0]   rdata_q, rdata_d;
    logic          err_q, err_d;

    logic [2:0] dec_hsize;
    logic [1:0] dec_addr_lo;
    logic       dec_legal;

    // The low address bits always come from the byte-select decode.
    logic unused_req_addr_lo;
    assign unused_req_addr_lo = ^req_addr[1:0];

    nanorv32_ahb_bytesel_decode u_bytesel_decode (
        .bytesel_i (req_bytesel),
        .hsize_o   (dec_hsize),
        .addr_lo_o (dec_addr_lo),
        .legal_o   (dec_legal)
    );

    always_comb begin
        state_d  = state_q;
        haddr_d  = haddr_q;
        htrans_d = htrans_q;
        hwrite_d = hwrite_q;
        hsize_d  = hsize_q;
        hwdata_d = hwdata_q;
        wdata_d  = wdata_q;
        ready_d  = 1'b0;
        rdata_d  = rdata_q;
        err_d    = err_q;

        case (state_q)
            StIdle: begin
                if (req_en) begin
                    if (dec_legal) begin
                        haddr_d  = {req_addr[AW-1:2], dec_addr_lo};
                        hwrite_d = req_we;
                        hsize_d  = dec_hsize;
                        htrans_d = HTRANS_NONSEQ;
                        wdata_d  = req_wdata;
                        state_d  = StAddr;
                    end else begin
                        // Rejected locally; DONE raises the pulse one cycle later.
                        err_d   = 1'b1;
                        rdata_d = '0;
                        state_d = StDone;
                    end
                end
            end

            StAddr: begin
                if (hready) begin
                    htrans_d = HTRANS_IDLE;
                    hwdata_d = hwrite_q ? wdata_q : '0;
                    state_d  = StData;
                end
            end

            StData: begin
                if (hresp) begin
                    hwdata_d = '0;
                    if (hready) begin
                        err_d   = 1'b1;
                        rdata_d = '0;
                        ready_d = 1'b1;
                        state_d = StDone;
                    end else begin
                        state_d = StErr2;
                    end
                end else if (hready) begin
                    hwdata_d = '0;
                    err_d    = 1'b0;
                    rdata_d  = hwrite_q ? '0 : hrdata;
                    ready_d  = 1'b1;
                    state_d  = StDone;
                end
            end

            StErr2: begin
                if (hready) begin
                    err_d   = 1'b1;
                    rdata_d = '0;
                    ready_d = 1'b1;
                    state_d = StDone;
                end
            end

            StDone: begin
                // Bus completions arrive with the pulse already set; a local
                // reject enters with it clear and spends one extra cycle here.
                if (ready_q) begin
                    state_d = StIdle;
                end else begin
                    ready_d = 1'b1;
                end
            end

            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= StIdle;
            haddr_q  <= '0;
            htrans_q <= HTRANS_IDLE;
            hwrite_q <= 1'b0;
            hsize_q  <= HSIZE_BYTE;
            hwdata_q <= '0;
            wdata_q  <= '0;
            ready_q  <= 1'b0;
            rdata_q  <= '0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            haddr_q  <= haddr_d;
            htrans_q <= htrans_d;
            hwrite_q <= hwrite_d;
            hsize_q  <= hsize_d;
            hwdata_q <= hwdata_d;
            wdata_q  <= wdata_d;
            ready_q  <= ready_d;
            rdata_q  <= rdata_d;
            err_q    <= err_d;
        end
    end

    assign haddr     = haddr_q;
    assign htrans    = htrans_q;
    assign hwrite    = hwrite_q;
    assign hsize     = hsize_q;
    assign hwdata    = hwdata_q;
    assign hburst    = HBURST_SINGLE;
    assign hprot     = HPROT_VAL;
    assign hmastlock = 1'b0;
    assign req_ready = ready_q;
    assign req_rdata = rdata_q;
    assign req_err   = err_q;

endmodule
